// File: rtl/inside_match_stage.sv
// -----------------------------------------------------------------------------
// inside_match_stage
//
// Purpose:
//   Two-stage valid/ready pipeline that checks each incoming data beat for
//   membership in a programmable table of SET_DEPTH values. Each beat is
//   forwarded unchanged, together with a hit flag and the lowest matching
//   table index. Running hit and miss counters (saturating) are kept for
//   every beat handed to the downstream consumer.
//
// Ports:
//   clk          - single rising-edge clock
//   rst_n        - asynchronous active-low reset
//   set_wr_en    - write one table entry this cycle (entry becomes valid)
//   set_wr_idx   - index of the entry to write
//   set_wr_data  - value to write
//   set_clear    - invalidate every entry (wins over a same-cycle write)
//   in_valid     - upstream beat valid
//   in_ready     - stage can accept a beat this cycle
//   in_data      - upstream beat
//   out_valid    - result beat valid
//   out_ready    - downstream accepts the result
//   out_data     - forwarded beat
//   out_hit      - beat matched at least one valid entry
//   out_hit_idx  - lowest matching index, 0 on a miss
//   hit_count    - saturating count of hits handed downstream
//   miss_count   - saturating count of misses handed downstream
// -----------------------------------------------------------------------------
module inside_match_stage #(
   parameter int DATA_W    = 8,
   parameter int SET_DEPTH = 8,
   parameter int IDX_W     = $clog2(SET_DEPTH),
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_wr_en,
   input  logic [IDX_W-1:0]  set_wr_idx,
   input  logic [DATA_W-1:0] set_wr_data,
   input  logic              set_clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_hit,
   output logic [IDX_W-1:0]  out_hit_idx,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   // ---------------------------------------------------------------------
   // Pipeline registers
   // ---------------------------------------------------------------------
   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_data_q,  s1_data_d;

   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] s2_data_q,  s2_data_d;
   logic              s2_hit_q,   s2_hit_d;
   logic [IDX_W-1:0]  s2_idx_q,   s2_idx_d;

   logic [CNT_W-1:0]  hit_count_q,  hit_count_d;
   logic [CNT_W-1:0]  miss_count_q, miss_count_d;

   logic              s2_adv;
   logic              s1_adv;
   logic              out_fire;

   // Per-entry compare result against the beat currently held in S1
   logic [SET_DEPTH-1:0] match;
   logic                 hit_c;
   logic [IDX_W-1:0]     idx_c;

   // ---------------------------------------------------------------------
   // Set table: one valid bit plus one value per entry. Compares read the
   // registered contents, so a write lands for compares one cycle later.
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < SET_DEPTH; gi++) begin : g_ent
         logic              ent_valid_q, ent_valid_d;
         logic [DATA_W-1:0] ent_val_q,   ent_val_d;

         always_comb begin
            ent_valid_d = ent_valid_q;
            ent_val_d   = ent_val_q;
            if (set_clear) begin
               // Clear only drops the valid bit; a same-cycle write is lost.
               ent_valid_d = 1'b0;
            end else if (set_wr_en && (set_wr_idx == IDX_W'(gi))) begin
               ent_valid_d = 1'b1;
               ent_val_d   = set_wr_data;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ent_valid_q <= 1'b0;
               ent_val_q   <= '0;
            end else begin
               ent_valid_q <= ent_valid_d;
               ent_val_q   <= ent_val_d;
            end
         end

         assign match[gi] = ent_valid_q && (ent_val_q == s1_data_q);
      end
   endgenerate

   // Lowest matching index wins: scan from the top down so that the last
   // assignment made is the smallest matching index.
   always_comb begin
      hit_c = |match;
      idx_c = '0;
      for (int i = SET_DEPTH - 1; i >= 0; i--) begin
         if (match[i]) begin
            idx_c = IDX_W'(i);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Handshake. in_ready depends only on the stage valids and out_ready,
   // never on in_valid, so there is no combinational in_valid->in_ready loop.
   // ---------------------------------------------------------------------
   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;
   assign out_fire = s2_valid_q && out_ready;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d = in_data;
         end
      end
   end

   // S2 payload is only reloaded when a real beat moves in, so out_* keep
   // their last values while out_valid is low and while stalled.
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_hit_d   = s2_hit_q;
      s2_idx_d   = s2_idx_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d = s1_data_q;
            s2_hit_d  = hit_c;
            s2_idx_d  = idx_c;
         end
      end
   end

   // Saturating statistics, bumped only when a result is handed downstream.
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (out_fire) begin
         if (s2_hit_q) begin
            if (hit_count_q != {CNT_W{1'b1}}) begin
               hit_count_d = hit_count_q + CNT_W'(1);
            end
         end else begin
            if (miss_count_q != {CNT_W{1'b1}}) begin
               miss_count_d = miss_count_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_data_q    <= '0;
         s2_valid_q   <= 1'b0;
         s2_data_q    <= '0;
         s2_hit_q     <= 1'b0;
         s2_idx_q     <= '0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_data_q    <= s1_data_d;
         s2_valid_q   <= s2_valid_d;
         s2_data_q    <= s2_data_d;
         s2_hit_q     <= s2_hit_d;
         s2_idx_q     <= s2_idx_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign out_valid   = s2_valid_q;
   assign out_data    = s2_data_q;
   assign out_hit     = s2_hit_q;
   assign out_hit_idx = s2_idx_q;
   assign hit_count   = hit_count_q;
   assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_inside_match_stage.sv
// -----------------------------------------------------------------------------
// tb_inside_match_stage
//
// Directed scenarios plus a randomized phase. A behavioural model (a queue of
// in-flight beats and a plain table array) predicts every output each cycle;
// directed scenarios also pin hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_inside_match_stage;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int IW    = 3;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          set_wr_en = 1'b0;
   logic [IW-1:0] set_wr_idx = '0;
   logic [DW-1:0] set_wr_data = '0;
   logic          set_clear = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_hit;
   logic [IW-1:0] out_hit_idx;
   logic [CW-1:0] hit_count;
   logic [CW-1:0] miss_count;

   inside_match_stage #(
      .DATA_W(DW), .SET_DEPTH(DEPTH), .IDX_W(IW), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .set_wr_en(set_wr_en), .set_wr_idx(set_wr_idx),
      .set_wr_data(set_wr_data), .set_clear(set_clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_hit(out_hit), .out_hit_idx(out_hit_idx),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------
   typedef struct {
      logic [DW-1:0] data;
      bit            cmp;   // compare done: beat is the presented result
      bit            hit;
      int            idx;
   } beat_t;

   beat_t         q[$];
   bit            m_vld [DEPTH];
   logic [DW-1:0] m_val [DEPTH];
   logic [DW-1:0] m_last_data = '0;
   bit            m_last_hit  = 1'b0;
   int            m_last_idx  = 0;
   int            m_hits      = 0;
   int            m_misses    = 0;

   function automatic void lookup(input logic [DW-1:0] d, output bit h, output int ix);
      h  = 1'b0;
      ix = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!h && m_vld[i] && m_val[i] == d) begin
            h  = 1'b1;
            ix = i;
         end
      end
   endfunction

   function automatic bit m_has_out();
      return (q.size() > 0) && q[0].cmp;
   endfunction

   function automatic bit m_has_in();
      return (q.size() > 0) && !q[q.size()-1].cmp;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         for (int i = 0; i < DEPTH; i++) begin
            m_vld[i] = 1'b0;
            m_val[i] = '0;
         end
         m_last_data = '0;
         m_last_hit  = 1'b0;
         m_last_idx  = 0;
         m_hits      = 0;
         m_misses    = 0;
      end else begin
         bit    ho, hi, oadv, rdy, h;
         int    ix;
         beat_t b;
         ho   = m_has_out();
         hi   = m_has_in();
         oadv = !ho || out_ready;
         rdy  = !hi || oadv;
         if (ho && out_ready) begin
            if (q[0].hit) begin
               if (m_hits < CMAX) m_hits++;
            end else begin
               if (m_misses < CMAX) m_misses++;
            end
            void'(q.pop_front());
         end
         if (hi && oadv) begin
            b = q[q.size()-1];
            lookup(b.data, h, ix);
            b.cmp = 1'b1;
            b.hit = h;
            b.idx = ix;
            q[q.size()-1] = b;
            m_last_data = b.data;
            m_last_hit  = h;
            m_last_idx  = ix;
         end
         if (in_valid && rdy) begin
            b.data = in_data;
            b.cmp  = 1'b0;
            b.hit  = 1'b0;
            b.idx  = 0;
            q.push_back(b);
         end
         if (set_clear) begin
            for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
         end else if (set_wr_en) begin
            m_vld[set_wr_idx] = 1'b1;
            m_val[set_wr_idx] = set_wr_data;
         end
      end
   end

   // ------------------------------------------------------------------
   // Per-cycle compare against the model (sampled on the falling edge)
   // ------------------------------------------------------------------
   logic [DW-1:0] obs[$];
   bit            saw_block = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         bit ho, hi;
         ho = m_has_out();
         hi = m_has_in();
         chk("in_ready",    int'(in_ready),    int'(!hi || !ho || out_ready));
         chk("out_valid",   int'(out_valid),   int'(ho));
         chk("out_data",    int'(out_data),    int'(m_last_data));
         chk("out_hit",     int'(out_hit),     int'(m_last_hit));
         chk("out_hit_idx", int'(out_hit_idx), m_last_idx);
         chk("hit_count",   int'(hit_count),   m_hits);
         chk("miss_count",  int'(miss_count),  m_misses);
         if (!in_ready) saw_block = 1'b1;
         if (out_valid && out_ready) begin
            obs.push_back(out_data);
            $display("out data=%0d hit=%0d idx=%0d hits=%0d misses=%0d",
                     out_data, out_hit, out_hit_idx, hit_count, miss_count);
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      set_wr_en = 1'b0;
      set_clear = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wr(input int idx, input int val);
      set_wr_en   = 1'b1;
      set_wr_idx  = IW'(idx);
      set_wr_data = DW'(val);
      tick();
      set_wr_en   = 1'b0;
   endtask

   task automatic clear_set();
      set_clear = 1'b1;
      tick();
      set_clear = 1'b0;
   endtask

   // Presents one beat and returns just after the edge that accepted it.
   // in_valid is left high so back-to-back calls stream without bubbles.
   task automatic send(input int val);
      bit acc;
      int n;
      in_valid = 1'b1;
      in_data  = DW'(val);
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         #2 acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      // Reset state
      do_reset();
      chk("rst_in_ready",  int'(in_ready),   1);
      chk("rst_out_valid", int'(out_valid),  0);
      chk("rst_out_data",  int'(out_data),   0);
      chk("rst_hits",      int'(hit_count),  0);
      chk("rst_misses",    int'(miss_count), 0);

      // Entries i*7, stream 21, 42, 5
      for (int i = 0; i < DEPTH; i++) wr(i, i * 7);
      send(21);
      chk("lat_not_yet", int'(out_valid), 0);
      send(42);
      chk("lat_valid",  int'(out_valid),   1);
      chk("t1_data0",   int'(out_data),    21);
      chk("t1_hit0",    int'(out_hit),     1);
      chk("t1_idx0",    int'(out_hit_idx), 3);
      send(5);
      chk("t1_data1",   int'(out_data),    42);
      chk("t1_idx1",    int'(out_hit_idx), 6);
      idle(3);
      chk("t1_data2",   int'(out_data),    5);
      chk("t1_hit2",    int'(out_hit),     0);
      chk("t1_idx2",    int'(out_hit_idx), 0);
      chk("t1_hits",    int'(hit_count),   2);
      chk("t1_misses",  int'(miss_count),  1);

      // Duplicate entries: lowest index wins
      clear_set();
      wr(2, 8'h10);
      wr(5, 8'h10);
      send(8'h10);
      idle(3);
      chk("dup_hit", int'(out_hit),     1);
      chk("dup_idx", int'(out_hit_idx), 2);

      // Clear beats a same-cycle write
      set_clear   = 1'b1;
      set_wr_en   = 1'b1;
      set_wr_idx  = '0;
      set_wr_data = 8'h10;
      tick();
      set_clear   = 1'b0;
      set_wr_en   = 1'b0;
      send(8'h10);
      idle(3);
      chk("clr_hit",  int'(out_hit),  0);
      chk("clr_data", int'(out_data), 8'h10);
      send(8'h00);
      idle(3);
      chk("empty_zero_hit", int'(out_hit), 0);

      // Write racing a compare: old contents used
      send(8'h2A);
      in_valid    = 1'b0;
      set_wr_en   = 1'b1;
      set_wr_idx  = 3'd3;
      set_wr_data = 8'h2A;
      tick();
      set_wr_en   = 1'b0;
      idle(3);
      chk("race_hit", int'(out_hit), 0);
      send(8'h2A);
      idle(3);
      chk("after_wr_hit", int'(out_hit),     1);
      chk("after_wr_idx", int'(out_hit_idx), 3);

      // Back-to-back stream with a 3-cycle downstream stall
      obs.delete();
      saw_block = 1'b0;
      fork
         begin
            for (int k = 1; k <= 6; k++) send(k);
            in_valid = 1'b0;
         end
         begin
            int w;
            w = 0;
            while (!out_valid && w < 20) begin
               tick();
               w++;
            end
            if (!out_valid) chk("stall_wait", 0, 1);
            out_ready = 1'b0;
            repeat (3) tick();
            out_ready = 1'b1;
         end
      join
      idle(6);
      chk("stall_block", int'(saw_block), 1);
      chk("stall_count", obs.size(), 6);
      for (int k = 0; k < 6; k++) begin
         chk("stall_order", (k < obs.size()) ? int'(obs[k]) : -1, k + 1);
      end

      // Hit counter saturation
      do_reset();
      wr(0, 8'h33);
      for (int k = 0; k < 20; k++) send(8'h33);
      idle(4);
      chk("sat_hits",   int'(hit_count),  CMAX);
      chk("sat_misses", int'(miss_count), 0);

      // Asynchronous reset with two beats in flight
      wr(1, 7);
      out_ready = 1'b0;
      send(7);
      send(7);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", int'(out_valid),  0);
      chk("arst_out_data",  int'(out_data),   0);
      chk("arst_hits",      int'(hit_count),  0);
      chk("arst_misses",    int'(miss_count), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      chk("arst_in_ready", int'(in_ready), 1);
      send(7);
      idle(3);
      chk("arst_first_miss", int'(out_hit), 0);
      chk("arst_first_data", int'(out_data), 7);

      // Randomized phase with occasional mid-cycle resets
      for (int c = 0; c < 800; c++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         in_data     = DW'($urandom_range(0, 15));
         out_ready   = ($urandom_range(0, 3) != 0);
         set_wr_en   = ($urandom_range(0, 7) == 0);
         set_wr_idx  = IW'($urandom_range(0, DEPTH - 1));
         set_wr_data = DW'($urandom_range(0, 15));
         set_clear   = ($urandom_range(0, 63) == 0);
         tick();
         if (c % 200 == 199) begin
            #2 rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
         end
      end
      set_wr_en = 1'b0;
      set_clear = 1'b0;
      out_ready = 1'b1;
      idle(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
